// File: rtl/dmem_ctrl.sv
// Data-memory controller for the RV32IM MA stage: B/H/W loads and stores with
// sign/zero extension, byte-lane writes, configurable wait states and a misalignment flag.
module dmem_ctrl #(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] address,
    input  logic [31:0] data_in,
    input  logic [2:0]  funct3,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic [31:0] data_out,
    output logic        busy,
    output logic        misaligned
);
    localparam int         AW  = $clog2(DEPTH_WORDS);
    localparam logic [3:0] LAT = 4'(LATENCY);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

    state_t        r_state;
    logic [3:0]    r_cnt;
    logic [31:0]   r_data_out;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_req;
    logic          w_fault;
    logic          w_commit;
    logic          w_signed;
    size_t         w_size;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_word;
    logic [31:0]   w_load;
    logic [31:0]   w_wdata;
    logic [3:0]    w_be;
    logic [7:0]    w_byte;
    logic [15:0]   w_half;
    logic          w_unused;

    assign w_req    = mem_read | mem_write;
    assign w_idx    = address[AW+1:2];
    assign w_signed = ~funct3[2];
    // Address bits above the array wrap silently.
    assign w_unused = ^{address[31:AW+2]};

    always_comb begin
        w_size = SZ_W;
        case (funct3)
            3'b000, 3'b100: w_size = SZ_B;
            3'b001, 3'b101: w_size = SZ_H;
            default:        w_size = SZ_W;
        endcase
    end

    always_comb begin
        w_fault = 1'b0;
        case (w_size)
            SZ_B:    w_fault = 1'b0;
            SZ_H:    w_fault = address[0];
            default: w_fault = |address[1:0];
        endcase
    end

    assign misaligned = w_req & w_fault & (r_state == IDLE);
    assign busy       = (r_state == ACCESS) | ((r_state == IDLE) & w_req & ~w_fault);
    assign w_commit   = (r_state == ACCESS) && (r_cnt == 4'd0);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_be    = 4'b1111;
        w_wdata = data_in;
        case (w_size)
            SZ_B: begin
                w_be    = 4'b0001 << address[1:0];
                w_wdata = {4{data_in[7:0]}};
            end
            SZ_H: begin
                w_be    = address[1] ? 4'b1100 : 4'b0011;
                w_wdata = {2{data_in[15:0]}};
            end
            default: ;
        endcase
    end

    // NOTE: the storage array is deliberately not reset; only control state is.
    always_ff @(posedge clk) begin
        if (!reset && w_commit && mem_write) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
            end
        end
    end

    assign w_word = r_mem[w_idx];
    assign w_byte = w_word[{address[1:0], 3'b000} +: 8];
    assign w_half = w_word[{address[1], 4'b0000} +: 16];

    always_comb begin
        w_load = w_word;
        case (w_size)
            SZ_B:    w_load = {{24{w_signed & w_byte[7]}}, w_byte};
            SZ_H:    w_load = {{16{w_signed & w_half[15]}}, w_half};
            default: w_load = w_word;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_cnt      <= 4'd0;
            r_data_out <= 32'h0000_0000;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_req && !w_fault) begin
                        r_state <= ACCESS;
                        r_cnt   <= LAT;
                    end
                end
                ACCESS: begin
                    if (r_cnt != 4'd0) begin
                        r_cnt <= r_cnt - 4'd1;
                    end else begin
                        r_state <= DONE;
                        if (!mem_write) r_data_out <= w_load;
                    end
                end
                DONE:    r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    assign data_out = r_data_out;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: three instances with different depth/latency, a byte-level
// reference model, and a monitor that checks each completed or faulted access.
module tb_dmem_ctrl;
    logic        clk = 1'b0;
    logic        rst_s  [3];
    logic [31:0] addr_s [3];
    logic [31:0] din_s  [3];
    logic [2:0]  f3_s   [3];
    logic        rd_s   [3];
    logic        wr_s   [3];
    logic [31:0] dout_s [3];
    logic        busy_s [3];
    logic        mis_s  [3];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : g_dut
        dmem_ctrl #(
            .DEPTH_WORDS(g == 2 ? 16 : 1024),
            .LATENCY    (g == 0 ? 2 : (g == 1 ? 3 : 0))
        ) u_dut (
            .clk       (clk),
            .reset     (rst_s[g]),
            .address   (addr_s[g]),
            .data_in   (din_s[g]),
            .funct3    (f3_s[g]),
            .mem_read  (rd_s[g]),
            .mem_write (wr_s[g]),
            .data_out  (dout_s[g]),
            .busy      (busy_s[g]),
            .misaligned(mis_s[g])
        );
    end

    function automatic int dw_of(input int g);
        return (g == 2) ? 16 : 1024;
    endfunction

    function automatic int lat_of(input int g);
        return (g == 0) ? 2 : ((g == 1) ? 3 : 0);
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        case (f3)
            3'b000, 3'b100: return 1;
            3'b001, 3'b101: return 2;
            default:        return 4;
        endcase
    endfunction

    function automatic int key(input int g, input logic [31:0] a);
        return g * (1 << 20) + int'(a & 32'(dw_of(g) * 4 - 1));
    endfunction

    typedef struct {
        int          id;
        int          inst;
        bit          mis;
        int          cycles;
        logic [31:0] data;
    } exp_t;

    exp_t        sb_q [$];
    exp_t        mon_e;
    logic [7:0]  mem_m [int];
    logic [31:0] dout_m [3];
    int          bcnt [3];
    int          op_id = 0;
    int          total = 0;
    int          bad   = 0;

    task automatic check(input string name, input int id, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s op%0d: got %h want %h", name, id, act, exp);
        end
    endtask

    // Byte-addressed reference: stores scatter bytes, loads gather and extend arithmetically.
    task automatic do_op(input int g, input bit rd, input bit wr, input logic [2:0] f3,
                         input logic [31:0] a, input logic [31:0] d);
        exp_t       e;
        int         s;
        int         n;
        bit         seen;
        longint     v;
        logic [7:0] b;
        s      = size_of(f3);
        e.id   = op_id++;
        e.inst = g;
        e.mis  = (a % 32'(s)) != 0;
        if (!e.mis) begin
            if (wr) begin
                for (int i = 0; i < s; i++) mem_m[key(g, a + 32'(i))] = d[8*i +: 8];
            end else begin
                v = 0;
                for (int i = 0; i < s; i++) begin
                    b = mem_m[key(g, a + 32'(i))];
                    v = v + (longint'(b) << (8 * i));
                end
                if (!f3[2] && s < 4 && v[8*s-1]) v = v - (longint'(1) << (8 * s));
                dout_m[g] = v[31:0];
            end
        end
        e.cycles = lat_of(g) + 2;
        e.data   = dout_m[g];
        sb_q.push_back(e);

        @(posedge clk); #1;
        addr_s[g] = a; din_s[g] = d; f3_s[g] = f3; rd_s[g] = rd; wr_s[g] = wr;
        if (e.mis) begin
            @(posedge clk); #1;
        end else begin
            n = 0;
            seen = 0;
            while (1) begin
                @(negedge clk);
                if (busy_s[g]) seen = 1;
                else if (seen) break;
                n++;
                if (n > 60) begin
                    total++;
                    bad++;
                    $display("FAIL timeout op%0d: busy never completed", e.id);
                    break;
                end
            end
            @(posedge clk); #1;
        end
        rd_s[g] = 0;
        wr_s[g] = 0;
    endtask

    // Store aborted by a reset pulse on the second ACCESS cycle.
    task automatic abort_store(input int g, input logic [31:0] a, input logic [31:0] d);
        exp_t e;
        e.id = op_id++; e.inst = g; e.mis = 0; e.cycles = 3; e.data = 32'h0;
        dout_m[g] = 32'h0;
        sb_q.push_back(e);
        @(posedge clk); #1;
        addr_s[g] = a; din_s[g] = d; f3_s[g] = 3'b010; wr_s[g] = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_s[g] = 1; wr_s[g] = 0;
        @(posedge clk); #1;
        rst_s[g] = 0;
        repeat (2) @(posedge clk);
    endtask

    always @(negedge clk) begin
        for (int g = 0; g < 3; g++) begin
            if (mis_s[g] || (!busy_s[g] && bcnt[g] > 0)) begin
                if (sb_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_response inst%0d", g);
                end else begin
                    mon_e = sb_q.pop_front();
                    check("instance", mon_e.id, 32'(g), 32'(mon_e.inst));
                    check("misaligned", mon_e.id, 32'(mis_s[g]), 32'(mon_e.mis));
                    check("busy_at_resp", mon_e.id, 32'(busy_s[g]), 32'd0);
                    if (!mis_s[g]) check("busy_cycles", mon_e.id, 32'(bcnt[g]), 32'(mon_e.cycles));
                    check("data_out", mon_e.id, dout_s[g], mon_e.data);
                end
                bcnt[g] = 0;
            end else if (busy_s[g]) begin
                bcnt[g]++;
            end
        end
    end

    initial begin
        logic [31:0] a;
        logic [2:0]  f3;
        int          r;
        for (int g = 0; g < 3; g++) begin
            rst_s[g] = 1; addr_s[g] = 0; din_s[g] = 0; f3_s[g] = 0;
            rd_s[g] = 0; wr_s[g] = 0; dout_m[g] = 0; bcnt[g] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) rst_s[g] = 0;
        @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            check("reset_data_out", -1, dout_s[g], 32'h0);
            check("reset_busy", -1, 32'(busy_s[g]), 32'd0);
            check("reset_misaligned", -1, 32'(mis_s[g]), 32'd0);
        end

        do_op(0, 0, 1, 3'b010, 32'h10, 32'hDEADBEEF);
        do_op(0, 1, 0, 3'b010, 32'h10, 32'h0);
        do_op(0, 0, 1, 3'b010, 32'h20, 32'h11223344);
        do_op(0, 0, 1, 3'b000, 32'h22, 32'hFFFFFFAA);
        do_op(0, 1, 0, 3'b010, 32'h20, 32'h0);
        do_op(0, 0, 1, 3'b001, 32'h20, 32'h77775566);
        do_op(0, 1, 0, 3'b010, 32'h20, 32'h0);
        do_op(0, 0, 1, 3'b010, 32'h40, 32'h80F07F01);
        do_op(0, 1, 0, 3'b000, 32'h42, 32'h0);
        do_op(0, 1, 0, 3'b100, 32'h42, 32'h0);
        do_op(0, 1, 0, 3'b001, 32'h42, 32'h0);
        do_op(0, 1, 0, 3'b101, 32'h40, 32'h0);
        do_op(0, 1, 0, 3'b010, 32'h41, 32'h0);
        do_op(0, 0, 1, 3'b001, 32'h23, 32'h0000BEEF);
        do_op(0, 1, 0, 3'b010, 32'h40, 32'h0);
        do_op(0, 1, 0, 3'b010, 32'h20, 32'h0);

        do_op(1, 0, 1, 3'b010, 32'h30, 32'h0);
        abort_store(1, 32'h30, 32'h12345678);
        do_op(1, 1, 0, 3'b010, 32'h30, 32'h0);

        do_op(2, 0, 1, 3'b010, 32'h40, 32'hCAFEF00D);
        do_op(2, 1, 0, 3'b010, 32'h00, 32'h0);

        for (int w = 0; w < 64; w++) do_op(0, 0, 1, 3'b010, 32'h100 + 32'(4 * w), $urandom);
        for (int w = 0; w < 16; w++) do_op(2, 0, 1, 3'b010, 32'(4 * w), $urandom);

        for (int k = 0; k < 300; k++) begin
            int g;
            g = (k % 2 == 0) ? 0 : 2;
            r = $urandom_range(0, 9);
            f3 = (r < 5) ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            a = $urandom;
            if (g == 0) a = (a & 32'hFFFFF0FF) | 32'h100;
            if ($urandom_range(0, 3) != 0) a = a & ~(32'(size_of(f3)) - 1);
            do_op(g, r >= 4, r < 5, f3, a, $urandom);
        end

        repeat (5) @(posedge clk);
        check("scoreboard_drained", -1, 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
